led7_scan_ctrl: RTL

LED7_SCAN_CTRL -- requirements
Module: led7_scan_ctrl

---
 rtl/led7_scan_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/led7_scan_ctrl.sv
// led7_scan_ctrl: time-multiplexed 7-segment digit scanner with a per-digit value store.
// Each digit is driven for PRESCALE cycles, followed by BLANK_CYCLES cycles of dead time.
module led7_scan_ctrl #(
    parameter int DIGITS       = 6,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      wr_en,
    input  logic [$clog2(DIGITS)-1:0] wr_addr,
    input  logic [3:0]                wr_data,
    input  logic [DIGITS-1:0]         blank_mask,
    output logic [DIGITS-1:0]         dig_sel,
    output logic [3:0]                dig_code,
    output logic                      frame_done
);
    localparam int AW = $clog2(DIGITS);
    localparam int CW = $clog2((PRESCALE > BLANK_CYCLES ? PRESCALE : BLANK_CYCLES) + 1);

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DIGITS-1:0] sel_q, sel_d;
    logic [3:0]        code_q, code_d;
    logic              done_q, done_d;
    logic              ready_q;
    logic              enter;
    logic [3:0]        store_q [DIGITS];
    logic [3:0]        store_d [DIGITS];

    always_comb begin
        store_d = store_q;
        if (wr_en && wr_addr <= AW'(DIGITS - 1))
            store_d[wr_addr] = wr_data;
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        code_d  = code_q;
        enter   = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            sel_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // ready_q delays the first scan by one edge after reset release
                    if (ready_q) begin
                        state_d = SHOW;
                        idx_d   = '0;
                        cnt_d   = '0;
                        enter   = 1'b1;
                    end
                end
                SHOW: begin
                    state_d = cnt_q == CW'(PRESCALE - 1) ? BLANK : SHOW;
                    cnt_d   = cnt_q == CW'(PRESCALE - 1) ? '0 : cnt_q + 1'b1;
                    sel_d   = cnt_q == CW'(PRESCALE - 1) ? '0 : sel_q;
                end
                BLANK: begin
                    if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                        idx_d   = idx_q == AW'(DIGITS - 1) ? '0 : idx_q + 1'b1;
                        enter   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // value and mask are captured once per slot, so later writes wait for the next visit
        if (enter) begin
            code_d = store_q[idx_d];
            sel_d  = blank_mask[idx_d] ? '0 : DIGITS'(1) << idx_d;
        end
        done_d = state_d == BLANK && cnt_d == CW'(BLANK_CYCLES - 1) && idx_q == AW'(DIGITS - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            code_q  <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            store_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            code_q  <= code_d;
            done_q  <= done_d;
            ready_q <= 1'b1;
            store_q <= store_d;
        end
    end

    assign dig_sel    = sel_q;
    assign dig_code   = code_q;
    assign frame_done = done_q;
endmodule
